// File: rtl/seg7_scan_if.sv
// Bus between a display source and the eight-digit scanner.
// Ports: data/dp/en/lzb in; an/seg/dp/frame out.
interface seg7_scan_if;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic        en_i;
    logic        lzb_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    modport master (
        output data_i, dp_i, en_i, lzb_i,
        input  an_o, seg_o, dp_o, frame_o
    );

    modport slave (
        input  data_i, dp_i, en_i, lzb_i,
        output an_o, seg_o, dp_o, frame_o
    );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with tear-free snapshots.
// Ports: clk_i, rst_i (async, active-low), bus (seg7_scan_if.slave).
module seg7_scan #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    seg7_scan_if.slave  bus
);
    localparam int unsigned CW =
        (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_data_q, snap_data_d;
    logic [7:0]    snap_dp_q, snap_dp_d;
    logic          snap_lzb_q, snap_lzb_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          wrap;
    logic [4:0]    sh;
    logic [3:0]    nib;
    logic          lz_blank;
    logic [6:0]    hex;

    always_comb begin
        tick        = (cnt_q == CNT_MAX);
        wrap        = tick && (idx_q == 3'd7);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        snap_data_d = snap_data_q;
        snap_dp_d   = snap_dp_q;
        snap_lzb_d  = snap_lzb_q;
        // New snapshot lands as digit 0 of the next frame starts.
        if (wrap) begin
            snap_data_d = bus.data_i;
            snap_dp_d   = bus.dp_i;
            snap_lzb_d  = bus.lzb_i;
        end
        frame_d = wrap;
    end

    always_comb begin
        sh  = {idx_q, 2'b00};
        nib = snap_data_q[sh +: 4];
        // Blank digit k when it and every digit to its left are zero.
        lz_blank = snap_lzb_q && (idx_q != 3'd0)
                   && ((snap_data_q >> sh) == 32'd0);
    end

    always_comb begin
        unique case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
        endcase
    end

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (bus.en_i && !lz_blank) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = hex;
            dp_d  = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            snap_data_q <= 32'd0;
            snap_dp_q   <= 8'd0;
            snap_lzb_q  <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_dp_q   <= snap_dp_d;
            snap_lzb_q  <= snap_lzb_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at PRESCALE=4 and PRESCALE=1.
// Expected outputs are queued per edge and popped at the falling edge.
module tb_seg7_scan;
    localparam int P = 4;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        string       tag;
        logic [16:0] val;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    seg7_scan_if a_if ();
    seg7_scan_if b_if ();

    seg7_scan #(.PRESCALE(P)) u_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (a_if.slave)
    );

    seg7_scan #(.PRESCALE(1)) u_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;
    exp_t sb_q [$];

    int          e;
    logic        in_rst;
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic        m_lzb;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t it;
            it = sb_q.pop_front();
            chk(it.tag,
                {15'd0, a_if.an_o, a_if.seg_o, a_if.dp_o, a_if.frame_o},
                {15'd0, it.val});
        end
    end

    // Predicts the outputs after the coming edge from the inputs
    // currently driven, then lets that edge happen.
    task automatic step(input string tag);
        exp_t       it;
        int         k;
        logic [7:0] an;
        logic [6:0] sg;
        logic       d;
        logic       fr;
        an = 8'hFF;
        sg = 7'h7F;
        d  = 1'b1;
        fr = 1'b0;
        if (!in_rst) begin
            e++;
            k  = ((e - 1) / P) % 8;
            fr = (e % (8 * P)) == 0;
            if (a_if.en_i &&
                !(k > 0 && m_lzb && (m_data >> (4 * k)) == 32'd0)) begin
                an = ~(8'd1 << k);
                sg = HEX[m_data[4*k +: 4]];
                d  = ~m_dp[k];
            end
            if (fr) begin
                m_data = a_if.data_i;
                m_dp   = a_if.dp_i;
                m_lzb  = a_if.lzb_i;
            end
        end
        it.tag = tag;
        it.val = {an, sg, d, fr};
        @(posedge clk);
        sb_q.push_back(it);
        #1;
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic model_reset();
        in_rst = 1'b1;
        e      = 0;
        m_data = 32'd0;
        m_dp   = 8'd0;
        m_lzb  = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_if.data_i = 32'h1234_5678;
        a_if.dp_i   = 8'h00;
        a_if.en_i   = 1'b1;
        a_if.lzb_i  = 1'b0;
        b_if.data_i = 32'h1234_5678;
        b_if.dp_i   = 8'h00;
        b_if.en_i   = 1'b1;
        b_if.lzb_i  = 1'b0;

        steps("reset", 3);
        rst_a  = 1'b1;
        in_rst = 1'b0;
        steps("first_frame", 64);

        a_if.data_i = 32'h0000_00A0;
        a_if.lzb_i  = 1'b1;
        steps("lzb_on", 64);
        a_if.lzb_i  = 1'b0;
        steps("lzb_off", 64);

        a_if.data_i = 32'h1111_1111;
        steps("tear_pre", 48);
        a_if.data_i = 32'h2222_2222;
        steps("tear_post", 48);

        steps("en_pre", 14);
        a_if.en_i = 1'b0;
        steps("en_off", 10);
        a_if.en_i = 1'b1;
        steps("en_on", 40);

        a_if.data_i = 32'h0;
        a_if.dp_i   = 8'h01;
        steps("dp", 64);

        steps("pre_rst", 14);
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        chk("async_rst",
            {15'd0, a_if.an_o, a_if.seg_o, a_if.dp_o, a_if.frame_o},
            {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
        model_reset();
        a_if.dp_i = 8'h00;
        steps("in_rst", 3);
        rst_a  = 1'b1;
        in_rst = 1'b0;
        steps("post_rst", 40);

        @(negedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);

        chk("b_reset",
            {15'd0, b_if.an_o, b_if.seg_o, b_if.dp_o, b_if.frame_o},
            {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
        rst_b = 1'b1;
        for (int eb = 1; eb <= 24; eb++) begin
            int         k;
            logic [6:0] sg;
            logic [31:0] v;
            @(posedge clk);
            #2;
            k  = (eb - 1) % 8;
            v  = 32'h1234_5678;
            sg = (eb > 8) ? HEX[v[4*k +: 4]] : 7'h40;
            chk("p1_scan",
                {15'd0, b_if.an_o, b_if.seg_o, b_if.dp_o, b_if.frame_o},
                {15'd0, ~(8'd1 << k), sg, 1'b1, (eb % 8) == 0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
